// File: rtl/ahb_timer_if.sv
// AHB-Lite slave-side signal bundle for ahb_timer; the decoder/master drives the address phase and HWDATA.
interface ahb_timer_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/ahb_timer.sv
// AHB-Lite timer: prescaled 32-bit down-counter, periodic/one-shot, level IRQ; TIMER_CAPTURE_EN adds capture_i.
// Zero wait states: reads return in the data phase, writes land at its end; HREADYOUT is never pulled low.
module ahb_timer #(
  parameter int PRESC_W = 8
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  ahb_timer_if.slave bus,
  input  logic       capture_i,
  output logic       irq_o
);

  localparam logic [2:0] OFF_LOAD    = 3'd0;
  localparam logic [2:0] OFF_VALUE   = 3'd1;
  localparam logic [2:0] OFF_CTRL    = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;
  localparam logic [2:0] OFF_CAPTURE = 3'd4;

  localparam logic [PRESC_W-1:0] PCNT_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  // data-phase state captured from the accepted address phase
  logic       dp_vld;
  logic       dp_wr;
  logic       dp_word;
  logic [2:0] dp_off;

  logic               addr_acc;
  logic               wr_vld;
  logic               wr_load;
  logic               wr_ctrl;
  logic               wr_status;

  logic [31:0]        load_q;
  logic [31:0]        value_q;
  logic               ctrl_en;
  logic               ctrl_ie;
  logic               ctrl_os;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] pcnt_q;
  logic               flag_q;
  logic               irq_q;

  logic               tick;
  logic               tick_eff;
  logic               expire;
  logic               pcnt_clr;
  logic               irq_src;
  logic               cflag_rd;
  logic [31:0]        capt_rd;
  logic [31:0]        ctrl_rd;
  logic [31:0]        rd_dat;

  assign addr_acc = bus.HSEL & bus.HREADY & bus.HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_vld  <= 1'b0;
      dp_wr   <= 1'b0;
      dp_word <= 1'b0;
      dp_off  <= 3'd0;
    end else begin
      dp_vld  <= addr_acc;
      dp_wr   <= bus.HWRITE;
      dp_word <= (bus.HSIZE == 3'b010);
      dp_off  <= bus.HADDR[4:2];
    end
  end

  assign wr_vld    = dp_vld & dp_wr & dp_word;
  assign wr_load   = wr_vld & (dp_off == OFF_LOAD);
  assign wr_ctrl   = wr_vld & (dp_off == OFF_CTRL);
  assign wr_status = wr_vld & (dp_off == OFF_STATUS);

  // a LOAD write restarts the period, so it swallows any tick landing on the same edge
  assign tick     = ctrl_en & (pcnt_q == presc_q);
  assign tick_eff = tick & ~wr_load;
  assign expire   = tick_eff & (value_q == 32'd0);
  assign pcnt_clr = wr_load | ~ctrl_en | tick | (wr_ctrl & ~ctrl_en & bus.HWDATA[0]);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pcnt_q <= '0;
    end else if (pcnt_clr) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PCNT_ONE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      load_q  <= 32'd0;
      value_q <= 32'd0;
    end else if (wr_load) begin
      load_q  <= bus.HWDATA;
      value_q <= bus.HWDATA;
    end else if (tick_eff) begin
      if (value_q != 32'd0) begin
        value_q <= value_q - 32'd1;
      end else if (!ctrl_os) begin
        value_q <= load_q;
      end
    end
  end

  // a firmware CTRL write beats the one-shot self-disable on the same edge
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_en <= 1'b0;
      ctrl_ie <= 1'b0;
      ctrl_os <= 1'b0;
      presc_q <= '0;
    end else if (wr_ctrl) begin
      ctrl_en <= bus.HWDATA[0];
      ctrl_ie <= bus.HWDATA[1];
      ctrl_os <= bus.HWDATA[2];
      presc_q <= bus.HWDATA[8 +: PRESC_W];
    end else if (expire && ctrl_os) begin
      ctrl_en <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= (flag_q & ~(wr_status & bus.HWDATA[0])) | expire;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0]  cap_sync;
  logic        cap_edge;
  logic        cflag_q;
  logic [31:0] capt_q;

  assign cap_edge = cap_sync[1] & ~cap_sync[2];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cap_sync <= 3'b000;
      cflag_q  <= 1'b0;
      capt_q   <= 32'd0;
    end else begin
      cap_sync <= {cap_sync[1:0], capture_i};
      cflag_q  <= (cflag_q & ~(wr_status & bus.HWDATA[1])) | cap_edge;
      if (cap_edge) begin
        capt_q <= value_q;
      end
    end
  end

  assign cflag_rd = cflag_q;
  assign capt_rd  = capt_q;
  assign irq_src  = flag_q | cflag_q;
`else
  logic unused_capture;
  assign unused_capture = capture_i;
  assign cflag_rd       = 1'b0;
  assign capt_rd        = 32'd0;
  assign irq_src        = flag_q;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ctrl_ie & irq_src;
    end
  end

  always_comb begin
    ctrl_rd              = 32'd0;
    ctrl_rd[0]           = ctrl_en;
    ctrl_rd[1]           = ctrl_ie;
    ctrl_rd[2]           = ctrl_os;
    ctrl_rd[8 +: PRESC_W] = presc_q;
  end

  always_comb begin
    rd_dat = 32'd0;
    if (dp_vld && !dp_wr) begin
      case (dp_off)
        OFF_LOAD:    rd_dat = load_q;
        OFF_VALUE:   rd_dat = value_q;
        OFF_CTRL:    rd_dat = ctrl_rd;
        OFF_STATUS:  rd_dat = {30'd0, cflag_rd, flag_q};
        OFF_CAPTURE: rd_dat = capt_rd;
        default:     rd_dat = 32'd0;
      endcase
    end
  end

  assign bus.HRDATA    = rd_dat;
  assign bus.HREADYOUT = 1'b1;
  assign irq_o         = irq_q;

  logic unused_bus;
  assign unused_bus = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0]};

endmodule

// File: tb/tb_ahb_timer.sv
// Scoreboarded bench for ahb_timer: cycle-level model predicts reads and irq_o; a negedge monitor compares.
module tb_ahb_timer;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic capture_i = 1'b0;
  logic irq_o;

  ahb_timer_if bus ();

  ahb_timer #(.PRESC_W(8)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus.slave),
    .capture_i (capture_i),
    .irq_o     (irq_o)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_exp[$];
  logic        irq_exp[$];

  // reference model of the programmer-visible state
  logic [31:0] m_load, m_value;
  bit          m_en, m_ie, m_os, m_flag, m_irq;
  int          m_presc, m_pcnt;

  // transfer currently in its data phase, as issued by the driver
  bit          dp_v, dp_w;
  bit [2:0]    dp_off, dp_sz;
  bit [31:0]   dp_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_value = 0; m_en = 0; m_ie = 0; m_os = 0;
    m_flag = 0; m_irq = 0; m_presc = 0; m_pcnt = 0;
  endtask

  function automatic logic [31:0] m_read(input bit [2:0] off);
    logic [31:0] r;
    r = 32'd0;
    case (off)
      3'd0: r = m_load;
      3'd1: r = m_value;
      3'd2: r = {16'd0, 8'(m_presc), 5'd0, m_os, m_ie, m_en};
      3'd3: r = {31'd0, m_flag};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // one HCLK edge: timebase ticks every (PRESC+1) cycles, a tick decrements or expires
  task automatic model_step(input bit w, input bit [2:0] off, input bit [31:0] wd);
    bit tick, load_wr, expire;
    logic [31:0] n_value;
    bit n_en;
    int n_pcnt;
    tick    = m_en && (m_pcnt == m_presc);
    load_wr = w && off == 3'd0;
    expire  = tick && !load_wr && m_value == 0;
    n_pcnt  = (load_wr || !m_en || tick) ? 0 : m_pcnt + 1;
    n_value = m_value;
    n_en    = m_en;
    if (load_wr) n_value = wd;
    else if (tick && m_value != 0) n_value = m_value - 1;
    else if (expire && !m_os) n_value = m_load;
    if (expire && m_os) n_en = 0;
    m_irq  = m_flag && m_ie;
    m_flag = (m_flag && !(w && off == 3'd3 && wd[0])) || expire;
    if (load_wr) m_load = wd;
    if (w && off == 3'd2) begin
      if (!m_en && wd[0]) n_pcnt = 0;
      n_en    = wd[0];
      m_ie    = wd[1];
      m_os    = wd[2];
      m_presc = int'(wd[15:8]);
    end
    m_en    = n_en;
    m_value = n_value;
    m_pcnt  = n_pcnt;
  endtask

  // one bus cycle: finish the pending data phase, advance the model, issue a new address phase
  task automatic bc(input bit rst, input bit sel, input bit tr, input bit wr,
                    input bit [2:0] off, input bit [2:0] sz, input bit [31:0] wd);
    bit [31:0] a;
    bit [1:0]  t0;
    @(posedge HCLK);
    #1;
    capture_i = ($urandom_range(7) == 0) ? ~capture_i : capture_i;
    if (rst) begin
      HRESETn = 1'b0;
      model_reset();
      dp_v = 0;
      bus.HSEL = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HWRITE = 1'b0;
      irq_exp.push_back(1'b0);
    end else begin
      HRESETn = 1'b1;
      bus.HWDATA = (dp_v && dp_w) ? dp_wd : $urandom;
      irq_exp.push_back(m_irq);
      if (dp_v && !dp_w) rd_exp.push_back(m_read(dp_off));
      model_step(dp_v && dp_w && dp_sz == 3'd2, dp_off, dp_wd);
      a = $urandom;
      a[4:2] = off;
      a[1:0] = 2'b00;
      t0 = 2'($urandom_range(1));
      bus.HSEL   = sel;
      bus.HTRANS = {tr, t0[0]};
      bus.HWRITE = wr;
      bus.HADDR  = a;
      bus.HSIZE  = sz;
      dp_v = sel && tr; dp_w = wr; dp_off = off; dp_sz = sz; dp_wd = wd;
    end
  endtask

  task automatic wr_reg(input bit [2:0] off, input bit [31:0] d); bc(0, 1, 1, 1, off, 3'd2, d); endtask
  task automatic rd_reg(input bit [2:0] off); bc(0, 1, 1, 0, off, 3'd2, 32'd0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) bc(0, 0, 0, 0, 3'd0, 3'd2, 32'd0); endtask
  task automatic rst_cycles(input int n); for (int i = 0; i < n; i++) bc(1, 0, 0, 0, 3'd0, 3'd2, 32'd0); endtask
  task automatic rd_all(); for (int i = 0; i < 8; i++) rd_reg(3'(i)); endtask

  // monitor: learns of read data phases from the bus itself and pops the scoreboard
  bit mon_rd = 0;
  always @(posedge HCLK)
    mon_rd = HRESETn && bus.HSEL && bus.HREADY && bus.HTRANS[1] && !bus.HWRITE;

  always @(negedge HCLK) begin
    chk("hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
    if (irq_exp.size() > 0) chk("irq_o", {31'd0, irq_o}, {31'd0, irq_exp.pop_front()});
    if (!HRESETn) begin
      chk("hrdata_in_reset", bus.HRDATA, 32'd0);
    end else if (mon_rd) begin
      if (rd_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_underflow actual=read_seen expected=no_read t=%0t", $time);
      end else begin
        chk("hrdata", bus.HRDATA, rd_exp.pop_front());
      end
    end
  end

  initial begin
    bit [2:0]  off;
    bit [31:0] wd;
    bus.HSEL = 0; bus.HREADY = 1; bus.HADDR = 0; bus.HTRANS = 0;
    bus.HWRITE = 0; bus.HSIZE = 3'd2; bus.HWDATA = 0;
    model_reset();
    dp_v = 0; dp_w = 0; dp_off = 0; dp_sz = 0; dp_wd = 0;

    rst_cycles(3);
    rd_all();

    // periodic, LOAD=4, PRESC=0, IE: flag every 5 cycles
    wr_reg(3'd0, 32'd4);
    wr_reg(3'd2, 32'h3);
    for (int i = 0; i < 14; i++) rd_reg(3'd1);
    rd_reg(3'd3);

    // one-shot, LOAD=2, PRESC=3: expiry after 12 cycles, EN self-clears
    wr_reg(3'd3, 32'd1);
    wr_reg(3'd0, 32'd2);
    wr_reg(3'd2, 32'h0307);
    for (int i = 0; i < 14; i++) rd_reg(3'd1);
    rd_reg(3'd2);
    rd_reg(3'd3);

    // W1C landing on the expiry edge, then a W1C on the following cycle
    wr_reg(3'd2, 32'h0);
    wr_reg(3'd3, 32'd1);
    wr_reg(3'd0, 32'd4);
    wr_reg(3'd2, 32'h3);
    idle(4);
    wr_reg(3'd3, 32'd1);
    rd_reg(3'd3);
    wr_reg(3'd3, 32'd1);
    rd_reg(3'd3);
    idle(2);
    wr_reg(3'd2, 32'h1);
    idle(8);
    rd_reg(3'd3);

    // sub-word write ignored, unmapped offset, back-to-back write/read
    bc(0, 1, 1, 1, 3'd0, 3'd0, 32'hDEAD_BEEF);
    rd_reg(3'd0);
    rd_reg(3'd7);
    wr_reg(3'd0, 32'h1234_5678);
    rd_reg(3'd0);

    // reset mid-count
    wr_reg(3'd0, 32'd50);
    wr_reg(3'd2, 32'h3);
    idle(10);
    rd_reg(3'd1);
    rst_cycles(2);
    rd_all();

    for (int n = 0; n < 3000; n++) begin
      off = ($urandom_range(5) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(3));
      wd = $urandom;
      if (off == 3'd0) wd = $urandom_range(12);
      if (off == 3'd2) wd[15:8] = 8'($urandom_range(3));
      if ($urandom_range(199) == 0) rst_cycles(1 + $urandom_range(1));
      else bc(0, $urandom_range(9) != 0, $urandom_range(5) != 0, $urandom_range(3) == 0,
              off, ($urandom_range(7) == 0) ? 3'($urandom_range(2)) : 3'd2, wd);
    end

    idle(3);
    @(negedge HCLK);
    #1;
    chk("rd_queue_drained", rd_exp.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
